ex_muldiv_ctrl: RTL and testbench
=================================

Name: ex_muldiv_ctrl

Overview:
- Sequencing controller between the EX stage and two shared multi-cycle units: the existing multiplier and an iterative divider.
- Accepts one mul/div request from EX and issues a single start pulse to the correct unit.
- Waits for the unit's end pulse, selects the result word, and holds it until the next stage accepts it.
- Also handles flush/drain of in-flight operations, divide-by-zero short-circuit, and a one-entry quotient/remainder reuse cache.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 3, request opcode width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  EX holds a valid mul/div op; held stable until accepted by the next stage or flushed
- req_op_i  in  OP_W  0 MUL, 1 MULH, 2 MULHU, 3 reserved (treated as MUL), 4 DIV, 5 MOD, 6 DIVU, 7 MODU
- req_opd1_i  in  DATA_W  rj
- req_opd2_i  in  DATA_W  rk
- flush_i  in  1  pipeline cancel
- out_ready_i  in  1  next stage allow-in
- busy_o  out  1  controller not IDLE or draining
- res_valid_o  out  1  result valid; EX uses this as its over signal
- res_o  out  DATA_W  selected result
- mul_start_o  out  1  one-cycle start pulse to the multiplier
- mul_signed_o  out  1  signed multiply
- mul_opd1_o, mul_opd2_o  out  DATA_W  registered operands
- mul_product_i  in  2*DATA_W  product
- mul_end_i  in  1  multiplier done pulse
- div_start_o  out  1  one-cycle start pulse to the divider
- div_signed_o  out  1  signed divide
- div_opd1_o, div_opd2_o  out  DATA_W  registered operands
- div_quot_i, div_rem_i  in  DATA_W  divider results
- div_end_i  in  1  divider done pulse

Behaviour:
- Reset values: state IDLE; all outputs 0; cache invalid; both drain flags 0.
- FSM states: IDLE, MWAIT, DWAIT, DONE.
- IDLE, accept condition: req_valid_i & !flush_i & no drain pending for the target unit.
  - MUL family: latch op/operands; the next cycle drives mul_start_o=1 for exactly one cycle; go to MWAIT.
  - DIV family, opd2==0: go directly to DONE with res=0; no unit start.
  - DIV family, cache hit: cache valid, opd1/opd2/signedness equal to the cached entry → DONE next cycle with cached quot (DIV/DIVU) or rem (MOD/MODU); no unit start.
  - Other DIV: div_start_o pulse next cycle; go to DWAIT.
- MWAIT, on mul_end_i:
  - res = product[31:0] for MUL, product[63:32] for MULH/MULHU.
  - Go to DONE; res_valid_o=1 the following cycle.
- DWAIT, on div_end_i:
  - res = quot or rem.
  - Write the cache (opd1, opd2, signed, quot, rem, valid=1).
  - Go to DONE.
- DONE: res_valid_o=1, res_o stable.
  - out_ready_i → IDLE next cycle.
  - A new request may be accepted in the first IDLE cycle.
- Latency, unit path: accept at T, start at T+1, end at E, res_valid_o at E+1.
- Latency, zero-divisor or cache hit: res_valid_o at T+1.
- End pulse while the FSM is not waiting for that unit and no drain is pending: ignored.
- Flush in MWAIT/DWAIT:
  - Next state is IDLE, res_valid_o=0.
  - Set drain flag for the busy unit.
  - The next end pulse from that unit clears the flag and is discarded; the cache is not written.
  - busy_o=1 while any drain flag is set.
  - Requests for the other unit may be accepted during the drain.
- Flush in DONE: drop the result, go to IDLE.
- Flush in the same cycle as the start pulse: start still issues (already registered), then the drain rule applies.
- Flush in the same cycle as an end pulse: the flush wins; the end pulse counts as the drain completion (flag not set).
- rst_i mid-operation: all state cleared; a later stale end pulse is ignored because the FSM is IDLE with no drain.
- Signed overflow case (0x80000000 / -1): defined by the divider; the controller passes its result through unchanged.

Decomposition:
- Shared package/header (common.vh): opcode localparams MD_MUL..MD_MODU, state encodings, DATA_W.
- One natural sub-module: md_div_cache (1-entry tag compare + quot/rem storage, write and invalidate ports).
- FSM and result select stay in the top module.

Test Plan:
- MUL 0xFFFFFFFF*0x2, multiplier ends 3 cycles after start → mul_start_o one pulse, res_o=0xFFFFFFFE; MULHU of the same operands → res_o=0x00000001; MULH → 0xFFFFFFFF.
- DIV 100/7 via the unit, then MOD 100/7 → first gives res_o=14 with one div_start_o; second gives res_o=2 with zero div_start_o, res_valid_o one cycle after accept.
- DIVU 5/0 → res_valid_o at T+1, res_o=0, no div_start_o.
- Flush during DWAIT, then an immediate new DIV → new request not accepted until the stale div_end_i arrives; the stale result is not returned or cached; the new DIV completes correctly.
- DONE held with out_ready_i=0 for 4 cycles → res_o stable, res_valid_o=1 throughout; out_ready_i=1 → IDLE next cycle.
- rst_i asserted in MWAIT, then mul_end_i pulses → all outputs 0, pulse ignored, busy_o=0.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared opcode/state types and op-class helpers for the EX mul/div sequencer.
package ex_muldiv_ctrl_pkg;

    localparam int unsigned MD_DATA_W = 32;
    localparam int unsigned MD_OP_W   = 3;

    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULH  = 3'd1,
        MD_MULHU = 3'd2,
        MD_RSVD  = 3'd3,
        MD_DIV   = 3'd4,
        MD_MOD   = 3'd5,
        MD_DIVU  = 3'd6,
        MD_MODU  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MWAIT = 2'd1,
        ST_DWAIT = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op inside {MD_DIV, MD_MOD, MD_DIVU, MD_MODU};
    endfunction

    function automatic logic md_is_rem(input md_op_e op);
        return op inside {MD_MOD, MD_MODU};
    endfunction

    function automatic logic md_div_signed(input md_op_e op);
        return op inside {MD_DIV, MD_MOD};
    endfunction

    function automatic logic md_mul_high(input md_op_e op);
        return op inside {MD_MULH, MD_MULHU};
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-side request/result handshake of the mul/div sequencer.
// master = EX / next stage, slave = the controller.
interface ex_muldiv_ctrl_if
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = MD_DATA_W,
    parameter int unsigned OP_W   = MD_OP_W
);
    logic              req_valid;
    logic [OP_W-1:0]   req_op;
    logic [DATA_W-1:0] req_opd1;
    logic [DATA_W-1:0] req_opd2;
    logic              flush;
    logic              out_ready;
    logic              busy;
    logic              res_valid;
    logic [DATA_W-1:0] res;

    modport master (
        output req_valid, req_op, req_opd1, req_opd2, flush, out_ready,
        input  busy, res_valid, res
    );

    modport slave (
        input  req_valid, req_op, req_opd1, req_opd2, flush, out_ready,
        output busy, res_valid, res
    );
endinterface

// File: rtl/ex_muldiv_ctrl_md_div_cache.sv
// One-entry divide result cache: tag is {opd1, opd2, signed}, data is {quot, rem}.
module md_div_cache #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inv_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wr_opd1_i,
    input  logic [DATA_W-1:0] wr_opd2_i,
    input  logic              wr_signed_i,
    input  logic [DATA_W-1:0] wr_quot_i,
    input  logic [DATA_W-1:0] wr_rem_i,
    input  logic [DATA_W-1:0] lk_opd1_i,
    input  logic [DATA_W-1:0] lk_opd2_i,
    input  logic              lk_signed_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] quot_o,
    output logic [DATA_W-1:0] rem_o
);
    logic              valid_q, valid_d;
    logic              signed_q, signed_d;
    logic [DATA_W-1:0] opd1_q, opd1_d;
    logic [DATA_W-1:0] opd2_q, opd2_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;

    // Next entry: write replaces the entry, invalidate has the last word.
    always_comb begin
        valid_d  = valid_q;
        signed_d = signed_q;
        opd1_d   = opd1_q;
        opd2_d   = opd2_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        if (we_i) begin
            valid_d  = 1'b1;
            signed_d = wr_signed_i;
            opd1_d   = wr_opd1_i;
            opd2_d   = wr_opd2_i;
            quot_d   = wr_quot_i;
            rem_d    = wr_rem_i;
        end
        if (inv_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            signed_q <= 1'b0;
            opd1_q   <= '0;
            opd2_q   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            signed_q <= signed_d;
            opd1_q   <= opd1_d;
            opd2_q   <= opd2_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
        end
    end

    // Tag compare against the request currently presented.
    always_comb begin
        hit_o  = valid_q && (opd1_q == lk_opd1_i) && (opd2_q == lk_opd2_i)
                 && (signed_q == lk_signed_i);
        quot_o = quot_q;
        rem_o  = rem_q;
    end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Sequencer between EX and the shared multiplier/divider: start, wait, select, hold.
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = MD_DATA_W,
    parameter int unsigned OP_W   = MD_OP_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ex_muldiv_ctrl_if.slave     ex,
    output logic                mul_start_o,
    output logic                mul_signed_o,
    output logic [DATA_W-1:0]   mul_opd1_o,
    output logic [DATA_W-1:0]   mul_opd2_o,
    input  logic [2*DATA_W-1:0] mul_product_i,
    input  logic                mul_end_i,
    output logic                div_start_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_opd1_o,
    output logic [DATA_W-1:0]   div_opd2_o,
    input  logic [DATA_W-1:0]   div_quot_i,
    input  logic [DATA_W-1:0]   div_rem_i,
    input  logic                div_end_i
);
    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic              mul_start_q, mul_start_d, mul_signed_q, mul_signed_d;
    logic              div_start_q, div_start_d, div_signed_q, div_signed_d;
    logic [DATA_W-1:0] mul_opd1_q, mul_opd1_d, mul_opd2_q, mul_opd2_d;
    logic [DATA_W-1:0] div_opd1_q, div_opd1_d, div_opd2_q, div_opd2_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              mdrain_q, mdrain_d, ddrain_q, ddrain_d;

    md_op_e            req_op;
    logic              req_div, req_dsigned, req_zero, req_blocked, accept;
    logic              cache_we, cache_hit;
    logic [DATA_W-1:0] cache_quot, cache_rem;

    md_div_cache #(.DATA_W(DATA_W)) u_div_cache (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inv_i       (1'b0),
        .we_i        (cache_we),
        .wr_opd1_i   (div_opd1_q),
        .wr_opd2_i   (div_opd2_q),
        .wr_signed_i (div_signed_q),
        .wr_quot_i   (div_quot_i),
        .wr_rem_i    (div_rem_i),
        .lk_opd1_i   (ex.req_opd1),
        .lk_opd2_i   (ex.req_opd2),
        .lk_signed_i (req_dsigned),
        .hit_o       (cache_hit),
        .quot_o      (cache_quot),
        .rem_o       (cache_rem)
    );

    // Decode the presented request; a unit still draining a flushed op blocks its family.
    always_comb begin
        req_op      = md_op_e'(ex.req_op[2:0]);
        req_div     = md_is_div(req_op);
        req_dsigned = md_div_signed(req_op);
        req_zero    = (ex.req_opd2 == '0);
        req_blocked = req_div ? ddrain_q : mdrain_q;
        accept      = (state_q == ST_IDLE) && ex.req_valid && !ex.flush && !req_blocked;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush always wins over a same-cycle end pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!req_div)                   state_d = ST_MWAIT;
                    else if (req_zero || cache_hit) state_d = ST_DONE;
                    else                            state_d = ST_DWAIT;
                end
            end
            ST_MWAIT: begin
                if (ex.flush)      state_d = ST_IDLE;
                else if (mul_end_i) state_d = ST_DONE;
            end
            ST_DWAIT: begin
                if (ex.flush)      state_d = ST_IDLE;
                else if (div_end_i) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (ex.flush || ex.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: operand latch, start pulses, result select, drain tracking.
    always_comb begin
        op_d         = op_q;
        mul_start_d  = 1'b0;
        div_start_d  = 1'b0;
        mul_signed_d = mul_signed_q;
        div_signed_d = div_signed_q;
        mul_opd1_d   = mul_opd1_q;
        mul_opd2_d   = mul_opd2_q;
        div_opd1_d   = div_opd1_q;
        div_opd2_d   = div_opd2_q;
        res_d        = res_q;
        cache_we     = 1'b0;
        // The first end pulse after a flush belongs to the cancelled op.
        mdrain_d     = mdrain_q && !mul_end_i;
        ddrain_d     = ddrain_q && !div_end_i;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = req_op;
                    if (!req_div) begin
                        mul_start_d  = 1'b1;
                        mul_signed_d = (req_op == MD_MULH);
                        mul_opd1_d   = ex.req_opd1;
                        mul_opd2_d   = ex.req_opd2;
                    end else if (req_zero) begin
                        res_d = '0;
                    end else if (cache_hit) begin
                        res_d = md_is_rem(req_op) ? cache_rem : cache_quot;
                    end else begin
                        div_start_d  = 1'b1;
                        div_signed_d = req_dsigned;
                        div_opd1_d   = ex.req_opd1;
                        div_opd2_d   = ex.req_opd2;
                    end
                end
            end
            ST_MWAIT: begin
                if (ex.flush) begin
                    mdrain_d = !mul_end_i;
                end else if (mul_end_i) begin
                    res_d = md_mul_high(op_q) ? mul_product_i[2*DATA_W-1:DATA_W]
                                              : mul_product_i[DATA_W-1:0];
                end
            end
            ST_DWAIT: begin
                if (ex.flush) begin
                    ddrain_d = !div_end_i;
                end else if (div_end_i) begin
                    res_d    = md_is_rem(op_q) ? div_rem_i : div_quot_i;
                    cache_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q         <= MD_MUL;
            mul_start_q  <= 1'b0;
            div_start_q  <= 1'b0;
            mul_signed_q <= 1'b0;
            div_signed_q <= 1'b0;
            mul_opd1_q   <= '0;
            mul_opd2_q   <= '0;
            div_opd1_q   <= '0;
            div_opd2_q   <= '0;
            res_q        <= '0;
            mdrain_q     <= 1'b0;
            ddrain_q     <= 1'b0;
        end else begin
            op_q         <= op_d;
            mul_start_q  <= mul_start_d;
            div_start_q  <= div_start_d;
            mul_signed_q <= mul_signed_d;
            div_signed_q <= div_signed_d;
            mul_opd1_q   <= mul_opd1_d;
            mul_opd2_q   <= mul_opd2_d;
            div_opd1_q   <= div_opd1_d;
            div_opd2_q   <= div_opd2_d;
            res_q        <= res_d;
            mdrain_q     <= mdrain_d;
            ddrain_q     <= ddrain_d;
        end
    end

    // Outputs: all registered except the state/drain-derived status.
    always_comb begin
        ex.busy      = (state_q != ST_IDLE) || mdrain_q || ddrain_q;
        ex.res_valid = (state_q == ST_DONE);
        ex.res       = res_q;
        mul_start_o  = mul_start_q;
        mul_signed_o = mul_signed_q;
        mul_opd1_o   = mul_opd1_q;
        mul_opd2_o   = mul_opd2_q;
        div_start_o  = div_start_q;
        div_signed_o = div_signed_q;
        div_opd1_o   = div_opd1_q;
        div_opd2_o   = div_opd2_q;
    end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl with behavioural multiplier/divider responders.
module tb_ex_muldiv_ctrl;
    import ex_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_start, mul_signed, mul_end;
    logic [31:0] mul_opd1, mul_opd2;
    logic [63:0] mul_product;
    logic        div_start, div_signed, div_end;
    logic [31:0] div_opd1, div_opd2, div_quot, div_rem;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned mul_starts = 0;
    int unsigned div_starts = 0;
    int unsigned mul_lat = 3;
    int unsigned div_lat = 4;

    ex_muldiv_ctrl_if #(.DATA_W(32), .OP_W(3)) ifc ();

    ex_muldiv_ctrl #(.DATA_W(32), .OP_W(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ex            (ifc),
        .mul_start_o   (mul_start),
        .mul_signed_o  (mul_signed),
        .mul_opd1_o    (mul_opd1),
        .mul_opd2_o    (mul_opd2),
        .mul_product_i (mul_product),
        .mul_end_i     (mul_end),
        .div_start_o   (div_start),
        .div_signed_o  (div_signed),
        .div_opd1_o    (div_opd1),
        .div_opd2_o    (div_opd2),
        .div_quot_i    (div_quot),
        .div_rem_i     (div_rem),
        .div_end_i     (div_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s.%s got=0x%0h exp=0x%0h", tag, what, got, exp);
    endtask

    // Start-pulse counters, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mul_start) mul_starts++;
            if (div_start) div_starts++;
        end
    end

    // Multiplier model: end pulse mul_lat cycles after the start cycle.
    initial begin : mul_unit
        logic [63:0] p;
        mul_end = 1'b0;
        mul_product = '0;
        forever begin
            @(negedge clk);
            if (mul_start) begin
                if (mul_signed) p = {{32{mul_opd1[31]}}, mul_opd1} * {{32{mul_opd2[31]}}, mul_opd2};
                else            p = {32'd0, mul_opd1} * {32'd0, mul_opd2};
                repeat (mul_lat) @(negedge clk);
                mul_product = p;
                mul_end = 1'b1;
                @(negedge clk);
                mul_end = 1'b0;
            end
        end
    end

    // Divider model: end pulse div_lat cycles after the start cycle.
    initial begin : div_unit
        logic [31:0] q, r;
        div_end = 1'b0;
        div_quot = '0;
        div_rem = '0;
        forever begin
            @(negedge clk);
            if (div_start) begin
                if (div_signed) begin
                    q = $signed(div_opd1) / $signed(div_opd2);
                    r = $signed(div_opd1) % $signed(div_opd2);
                end else begin
                    q = div_opd1 / div_opd2;
                    r = div_opd1 % div_opd2;
                end
                repeat (div_lat) @(negedge clk);
                div_quot = q;
                div_rem = r;
                div_end = 1'b1;
                @(negedge clk);
                div_end = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Present one request, wait for the result, hold it, then hand it off.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int unsigned exp_lat, input int unsigned exp_starts,
                          input int unsigned hold);
        int unsigned n0, lat;
        bit seen;
        n0 = mul_starts + div_starts;
        ifc.req_valid = 1'b1;
        ifc.req_op = op;
        ifc.req_opd1 = a;
        ifc.req_opd2 = b;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (ifc.res_valid) seen = 1'b1;
        end
        check(tag, "valid", 64'(seen), 64'd1);
        check(tag, "latency", 64'(lat), 64'(exp_lat));
        check(tag, "res", 64'(ifc.res), 64'(exp));
        check(tag, "starts", 64'(mul_starts + div_starts - n0), 64'(exp_starts));
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            check(tag, "hold_valid", 64'(ifc.res_valid), 64'd1);
            check(tag, "hold_res", 64'(ifc.res), 64'(exp));
        end
        ifc.out_ready = 1'b1;
        ifc.req_valid = 1'b0;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        check(tag, "after_ack", 64'({ifc.res_valid, ifc.busy}), 64'd0);
    endtask

    initial begin
        int unsigned d0, cnt;
        bit bad, seen;
        rst = 1'b1;
        ifc.req_valid = 1'b0;
        ifc.req_op = '0;
        ifc.req_opd1 = '0;
        ifc.req_opd2 = '0;
        ifc.flush = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", "busy", 64'(ifc.busy), 64'd0);
        check("reset", "res_valid", 64'(ifc.res_valid), 64'd0);
        check("reset", "res", 64'(ifc.res), 64'd0);
        check("reset", "starts", 64'({mul_start, div_start}), 64'd0);
        check("reset", "opds", 64'({mul_opd1, div_opd2}), 64'd0);
        rst = 1'b0;

        run_op("mul",   MD_MUL,   32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 5, 1, 0);
        run_op("mulhu", MD_MULHU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 5, 1, 0);
        run_op("mulh",  MD_MULH,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 5, 1, 0);
        run_op("rsvd_hold", MD_RSVD, 32'd3, 32'd5, 32'd15, 5, 1, 4);
        run_op("div",       MD_DIV,  32'd100, 32'd7, 32'd14, 6, 1, 0);
        run_op("mod_hit",   MD_MOD,  32'd100, 32'd7, 32'd2,  1, 0, 0);
        run_op("divu_miss", MD_DIVU, 32'd100, 32'd7, 32'd14, 6, 1, 0);
        run_op("divu_zero", MD_DIVU, 32'd5,   32'd0, 32'd0,  1, 0, 0);

        // Flush while the divider is busy, then immediately present a new divide.
        div_lat = 8;
        d0 = div_starts;
        ifc.req_valid = 1'b1;
        ifc.req_op = MD_DIV;
        ifc.req_opd1 = 32'd200;
        ifc.req_opd2 = 32'd3;
        @(negedge clk);
        check("flush", "start", 64'(div_start), 64'd1);
        @(negedge clk);
        ifc.flush = 1'b1;
        @(negedge clk);
        ifc.flush = 1'b0;
        ifc.req_opd1 = 32'd45;
        ifc.req_opd2 = 32'd6;
        check("flush", "valid_dropped", 64'(ifc.res_valid), 64'd0);
        check("flush", "busy_drain", 64'(ifc.busy), 64'd1);
        bad = 1'b0;
        seen = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            cnt++;
            if (ifc.res_valid) bad = 1'b1;
            if (div_start) seen = 1'b1;
        end
        check("flush", "drain_wait", 64'(cnt), 64'd8);
        check("flush", "no_stale_result", 64'(bad), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (ifc.res_valid) seen = 1'b1;
        end
        check("flush_new", "valid", 64'(seen), 64'd1);
        check("flush_new", "res", 64'(ifc.res), 64'd7);
        check("flush_new", "starts", 64'(div_starts - d0), 64'd2);
        ifc.out_ready = 1'b1;
        ifc.req_valid = 1'b0;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        div_lat = 4;

        // The flushed 200/3 must not have been cached: this goes to the unit.
        run_op("mod_nocache", MD_MOD, 32'd200, 32'd3, 32'd2, 6, 1, 0);

        // Flush in DONE drops a (cached) result.
        ifc.req_valid = 1'b1;
        ifc.req_op = MD_DIV;
        ifc.req_opd1 = 32'd200;
        ifc.req_opd2 = 32'd3;
        @(negedge clk);
        check("flush_done", "hit_valid", 64'(ifc.res_valid), 64'd1);
        check("flush_done", "hit_res", 64'(ifc.res), 64'd66);
        ifc.flush = 1'b1;
        ifc.req_valid = 1'b0;
        @(negedge clk);
        ifc.flush = 1'b0;
        check("flush_done", "dropped", 64'({ifc.res_valid, ifc.busy}), 64'd0);

        // Reset while the multiplier is busy; its later end pulse is ignored.
        ifc.req_valid = 1'b1;
        ifc.req_op = MD_MUL;
        ifc.req_opd1 = 32'd7;
        ifc.req_opd2 = 32'd6;
        @(negedge clk);
        check("rst_mid", "start", 64'(mul_start), 64'd1);
        rst = 1'b1;
        ifc.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", "busy", 64'(ifc.busy), 64'd0);
        check("rst_mid", "outs", 64'({ifc.res_valid, mul_start, div_start, ifc.res}), 64'd0);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifc.res_valid || ifc.busy || ifc.res != 32'd0) bad = 1'b1;
        end
        check("rst_mid", "stale_end_ignored", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
